qspi_register_bank: RTL and testbench

QSPI_REGISTER_BANK -- requirements
Module: qspi_register_bank

---
 rtl/qspi_register_bank_pkg.sv | 20 ++
 rtl/qspi_register_bank_if.sv | 24 ++
 rtl/qspi_register_bank_slot.sv | 71 +++++++
 rtl/qspi_register_bank.sv | 137 +++++++++++++
 tb/tb_qspi_register_bank.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_register_bank_pkg.sv
// Shared widths, FSM state type and counter helper for the QSPI register bank.
package qspi_regs_pkg;
   localparam int unsigned OPC_W  = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 8;

   typedef logic [OPC_W-1:0]  opcode_t;
   typedef logic [BYTE_W-1:0] byte_t;
   typedef logic [CNT_W-1:0]  count_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE
   } state_e;

   function automatic count_t sat_inc(count_t c);
      return (c == '1) ? c : c + count_t'(1);
   endfunction
endpackage

// File: rtl/qspi_register_bank_if.sv
// Byte-level handshake between the QSPI device core (master) and the register bank (slave).
interface qspi_register_bank_if;
   import qspi_regs_pkg::*;

   logic    start;
   logic    insn_valid;
   opcode_t insn;
   logic    wr_valid;
   byte_t   wr_data;
   logic    rd_ready;
   logic    rd_mode;
   logic    rd_valid;
   byte_t   rd_data;

   modport master (
      output start, insn_valid, insn, wr_valid, wr_data, rd_ready,
      input  rd_mode, rd_valid, rd_data
   );

   modport slave (
      input  start, insn_valid, insn, wr_valid, wr_data, rd_ready,
      output rd_mode, rd_valid, rd_data
   );
endinterface

// File: rtl/qspi_register_bank_slot.sv
// One register: collects write bytes in a shadow and commits them atomically on the last byte.
module qspi_reg_slot
   import qspi_regs_pkg::*;
#(
   parameter int unsigned            REG_BYTES   = 8,
   parameter int unsigned            LEN         = 4,
   parameter bit                     WRITABLE    = 1'b1,
   parameter logic [REG_BYTES*8-1:0] RESET_VALUE = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_i,
   input  logic                   wr_en_i,
   input  count_t                 count_i,
   input  byte_t                  wr_data_i,
   output logic [REG_BYTES*8-1:0] value_o,
   output logic                   updated_o
);
   localparam int unsigned W    = REG_BYTES * 8;
   localparam count_t      LAST = count_t'(LEN - 1);

   function automatic logic [W-1:0] len_mask();
      logic [W-1:0] m;
      m = '0;
      for (int unsigned b = 0; b < REG_BYTES; b++) begin
         if (b < LEN) m[b*8 +: 8] = '1;
      end
      return m;
   endfunction

   localparam logic [W-1:0] LEN_MASK = len_mask();
   localparam logic [W-1:0] INIT     = WRITABLE ? (RESET_VALUE & LEN_MASK) : '0;

   logic [W-1:0] shadow_q, shadow_d;
   logic [W-1:0] value_q, value_d;
   logic         updated_q, updated_d;
   int unsigned  pos;

   always_comb begin
      shadow_d  = shadow_q;
      value_d   = value_q;
      updated_d = 1'b0;
      pos       = 32'(LAST - count_i);
      if (clear_i) begin
         shadow_d = '0;
      end else if (wr_en_i && WRITABLE && (count_i <= LAST)) begin
         shadow_d[pos*8 +: 8] = wr_data_i;
         // the final byte is merged before the copy so the commit is one atomic update
         if (count_i == LAST) begin
            value_d   = shadow_d & LEN_MASK;
            updated_d = 1'b1;
            shadow_d  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q  <= '0;
         value_q   <= INIT;
         updated_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         value_q   <= value_d;
         updated_q <= updated_d;
      end
   end

   assign value_o   = value_q;
   assign updated_o = updated_q;
endmodule

// File: rtl/qspi_register_bank.sv
// QSPI opcode-addressed register bank: decodes opcodes, streams read bytes MSB first,
// and hands write bytes to per-register commit slots.
module qspi_register_bank
   import qspi_regs_pkg::*;
#(
   parameter int unsigned                      NUM_REGS    = 8,
   parameter int unsigned                      REG_BYTES   = 8,
   parameter logic [NUM_REGS*4-1:0]            REG_LEN     = {NUM_REGS{4'd4}},
   parameter logic [NUM_REGS-1:0]              RD_MASK     = '1,
   parameter logic [NUM_REGS-1:0]              WR_MASK     = '1,
   parameter logic [NUM_REGS*REG_BYTES*8-1:0]  RESET_VALUE = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   qspi_register_bank_if.slave               bus,
   input  logic [NUM_REGS*REG_BYTES*8-1:0]   ro_values,
   output logic [NUM_REGS*REG_BYTES*8-1:0]   reg_values,
   output logic [NUM_REGS-1:0]               reg_updated,
   output logic                              bad_opcode,
   input  logic                              bad_clear
);
   localparam int unsigned W     = REG_BYTES * 8;
   localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   state_e               state_q, state_d;
   count_t               count_q, count_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic                 rd_valid_q, rd_valid_d;
   byte_t                rd_data_q, rd_data_d;
   logic                 bad_q, bad_d;

   logic                 insn_rd, insn_wr;
   logic [3:0]           sel_len;
   logic [W-1:0]         sel_src;
   int unsigned          byte_idx;
   logic [NUM_REGS-1:0]  slot_wr;

   always_comb begin
      insn_rd = 1'b0;
      insn_wr = 1'b0;
      sel_len = '0;
      sel_src = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (32'(bus.insn) == i) begin
            insn_rd = RD_MASK[i];
            insn_wr = WR_MASK[i];
         end
         if (32'(sel_q) == i) begin
            sel_len = REG_LEN[i*4 +: 4];
            sel_src = WR_MASK[i] ? reg_values[i*W +: W] : ro_values[i*W +: W];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      sel_d      = sel_q;
      bad_d      = bad_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      byte_idx   = 32'(sel_len) - 32'(count_q) - 32'd1;
      if (bad_clear) bad_d = 1'b0;
      // start outranks any byte strobe in the same cycle
      if (bus.start) begin
         state_d = ST_IDLE;
         count_d = '0;
      end else begin
         if (bus.insn_valid) begin
            sel_d = SEL_W'(bus.insn);
            if (insn_rd) begin
               state_d = ST_READ;
            end else if (insn_wr) begin
               state_d = ST_WRITE;
            end else begin
               state_d = ST_IDLE;
               bad_d   = 1'b1;
            end
         end
         if (bus.rd_ready) begin
            rd_valid_d = 1'b1;
            rd_data_d  = '0;
            if (state_q == ST_READ) begin
               count_d = sat_inc(count_q);
               if (count_q < count_t'(sel_len)) rd_data_d = sel_src[byte_idx*8 +: 8];
            end
         end
         if (bus.wr_valid && (state_q == ST_WRITE)) count_d = sat_inc(count_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         sel_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         bad_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         sel_q      <= sel_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         bad_q      <= bad_d;
      end
   end

   always_comb begin
      slot_wr = '0;
      if ((state_q == ST_WRITE) && bus.wr_valid && !bus.start) slot_wr[sel_q] = 1'b1;
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
      qspi_reg_slot #(
         .REG_BYTES   (REG_BYTES),
         .LEN         (32'(REG_LEN[g*4 +: 4])),
         .WRITABLE    (WR_MASK[g]),
         .RESET_VALUE (RESET_VALUE[g*W +: W])
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .clear_i   (bus.start),
         .wr_en_i   (slot_wr[g]),
         .count_i   (count_q),
         .wr_data_i (bus.wr_data),
         .value_o   (reg_values[g*W +: W]),
         .updated_o (reg_updated[g])
      );
   end

   assign bus.rd_mode  = (state_q == ST_READ);
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bad_opcode   = bad_q;
endmodule

// File: tb/tb_qspi_register_bank.sv
// Randomized bench for qspi_register_bank against a transaction-level register model.
module tb_qspi_register_bank;
   localparam int          NR   = 8;
   localparam int          RB   = 8;
   localparam logic [31:0] LENS = 32'h1864_4444;
   localparam logic [7:0]  RDM  = 8'b0001_0001;
   localparam logic [7:0]  WRM  = 8'b1111_1100;
   localparam logic [NR*RB*8-1:0] RSTV = {8{64'hF0E1_D2C3_B4A5_9687}};

   logic                clk = 1'b0;
   logic                rst;
   logic [NR*RB*8-1:0]  ro_values;
   logic [NR*RB*8-1:0]  reg_values;
   logic [NR-1:0]       reg_updated;
   logic                bad_opcode;
   logic                bad_clear;

   qspi_register_bank_if bus ();

   qspi_register_bank #(
      .NUM_REGS    (NR),
      .REG_BYTES   (RB),
      .REG_LEN     (LENS),
      .RD_MASK     (RDM),
      .WR_MASK     (WRM),
      .RESET_VALUE (RSTV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .ro_values   (ro_values),
      .reg_values  (reg_values),
      .reg_updated (reg_updated),
      .bad_opcode  (bad_opcode),
      .bad_clear   (bad_clear)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] mdl [NR];
   bit          mdl_bad;
   logic [7:0]  tx_buf [16];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int len_of(input int r);
      return int'(LENS[r*4 +: 4]);
   endfunction

   function automatic logic [63:0] len_mask(input int r);
      int l;
      l = len_of(r);
      return (l >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*l)) - 64'd1);
   endfunction

   function automatic bit op_rd(input logic [15:0] op);
      return (op < 16'd8) && RDM[op[2:0]];
   endfunction

   function automatic bit op_wmode(input logic [15:0] op);
      return (op < 16'd8) && !RDM[op[2:0]] && WRM[op[2:0]];
   endfunction

   function automatic void model_reset();
      for (int r = 0; r < NR; r++)
         mdl[r] = WRM[r] ? (RSTV[r*64 +: 64] & len_mask(r)) : 64'd0;
      mdl_bad = 1'b0;
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic check_regs();
      for (int r = 0; r < NR; r++)
         check($sformatf("reg%0d", r), reg_values[r*64 +: 64], mdl[r]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      model_reset();
      check("rst_upd", 64'(reg_updated), 64'd0);
      check("rst_rdmode", 64'(bus.rd_mode), 64'd0);
      check("rst_rdvalid", 64'(bus.rd_valid), 64'd0);
      check("rst_rddata", 64'(bus.rd_data), 64'd0);
      check("rst_bad", 64'(bad_opcode), 64'd0);
      check_regs();
   endtask

   task automatic begin_txn(input logic [15:0] op, input bit clr);
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      check("start_rdmode", 64'(bus.rd_mode), 64'd0);
      bus.insn_valid = 1'b1;
      bus.insn       = op;
      bad_clear      = clr;
      cyc();
      bus.insn_valid = 1'b0;
      bad_clear      = 1'b0;
      if (!op_rd(op) && !op_wmode(op)) mdl_bad = 1'b1;
      else if (clr) mdl_bad = 1'b0;
      check("rd_mode", 64'(bus.rd_mode), 64'(op_rd(op)));
      check("bad_flag", 64'(bad_opcode), 64'(mdl_bad));
   endtask

   task automatic write_txn(input logic [15:0] op, input int n, input int coll);
      bit          wm;
      int          r, l;
      logic [63:0] acc, exp_upd;
      wm  = op_wmode(op);
      r   = int'(op[2:0]);
      l   = wm ? len_of(r) : 0;
      acc = '0;
      begin_txn(op, 1'b0);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 1)) begin
            cyc();
            check("gap_upd", 64'(reg_updated), 64'd0);
         end
         bus.wr_valid = 1'b1;
         bus.wr_data  = tx_buf[k];
         if (k == coll) bus.start = 1'b1;
         cyc();
         bus.wr_valid = 1'b0;
         bus.start    = 1'b0;
         if (k == coll) begin
            check("coll_upd", 64'(reg_updated), 64'd0);
            break;
         end
         exp_upd = '0;
         if (wm && k < l) acc = {acc[55:0], tx_buf[k]};
         if (wm && k == l - 1) begin
            mdl[r]  = acc;
            exp_upd = 64'd1 << r;
         end
         check("wr_upd", 64'(reg_updated), exp_upd);
         if (exp_upd != 0) check("commit_val", reg_values[r*64 +: 64], mdl[r]);
      end
      cyc();
      check("post_upd", 64'(reg_updated), 64'd0);
      check_regs();
   endtask

   task automatic read_txn(input logic [15:0] op, input int n, input bit rnd_ro, input bit clr);
      int          r, l;
      logic [63:0] src, exp;
      r = int'(op[2:0]);
      l = op_rd(op) ? len_of(r) : 0;
      begin_txn(op, clr);
      for (int k = 0; k < n; k++) begin
         if (rnd_ro)
            for (int w = 0; w < NR*RB/4; w++) ro_values[w*32 +: 32] = $urandom();
         exp = '0;
         if (k < l) begin
            src = WRM[r] ? mdl[r] : ro_values[r*64 +: 64];
            exp = (src >> (8*(l - 1 - k))) & 64'hFF;
         end
         bus.rd_ready = 1'b1;
         cyc();
         bus.rd_ready = 1'b0;
         check("rd_valid", 64'(bus.rd_valid), 64'd1);
         check("rd_data", 64'(bus.rd_data), exp);
         repeat ($urandom_range(0, 1)) begin
            cyc();
            check("rd_idle", 64'(bus.rd_valid), 64'd0);
         end
      end
   endtask

   task automatic clear_bad();
      bad_clear = 1'b1;
      cyc();
      bad_clear = 1'b0;
      mdl_bad   = 1'b0;
      check("bad_cleared", 64'(bad_opcode), 64'd0);
   endtask

   task automatic rd_coll();
      begin_txn(16'd0, 1'b0);
      bus.start    = 1'b1;
      bus.rd_ready = 1'b1;
      cyc();
      bus.start    = 1'b0;
      bus.rd_ready = 1'b0;
      check("coll_rdvalid", 64'(bus.rd_valid), 64'd0);
      check("coll_rdmode", 64'(bus.rd_mode), 64'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int op, n, coll;
      rst            = 1'b1;
      bad_clear      = 1'b0;
      ro_values      = '0;
      bus.start      = 1'b0;
      bus.insn_valid = 1'b0;
      bus.insn       = '0;
      bus.wr_valid   = 1'b0;
      bus.wr_data    = '0;
      bus.rd_ready   = 1'b0;
      cyc();
      do_reset();

      // four-byte write to reg 3
      tx_buf[0] = 8'h0A; tx_buf[1] = 8'h0B; tx_buf[2] = 8'h0C; tx_buf[3] = 8'h0D;
      write_txn(16'd3, 4, -1);
      check("reg3_const", reg_values[3*64 +: 64], 64'h0A0B_0C0D);

      // partial write then start
      tx_buf[0] = 8'h55; tx_buf[1] = 8'h66;
      write_txn(16'd2, 2, -1);
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      repeat (2) begin
         cyc();
         check("partial_upd", 64'(reg_updated), 64'd0);
      end
      check_regs();

      // read-only reg 0, one byte past its length
      ro_values[31:0] = 32'h1234_5678;
      read_txn(16'd0, 5, 1'b0, 1'b0);

      // bad opcode, sticky until cleared, set beats clear
      read_txn(16'h00FF, 1, 1'b0, 1'b0);
      repeat (2) begin
         cyc();
         check("bad_sticky", 64'(bad_opcode), 64'd1);
      end
      clear_bad();
      read_txn(16'h00FF, 1, 1'b0, 1'b1);
      check("bad_setwins", 64'(bad_opcode), 64'd1);
      clear_bad();

      // reset in the middle of a six-byte write, then a full write
      for (int i = 0; i < 6; i++) tx_buf[i] = 8'(8'h31 + i);
      write_txn(16'd5, 3, -1);
      do_reset();
      write_txn(16'd5, 6, -1);

      // start colliding with the last byte, then a clean write
      for (int i = 0; i < 4; i++) tx_buf[i] = 8'(8'hC0 + i);
      write_txn(16'd3, 4, 3);
      for (int i = 0; i < 4; i++) tx_buf[i] = 8'(8'hE0 + i);
      write_txn(16'd3, 4, -1);

      // length boundaries: 8-byte reg with overrun, 1-byte reg
      for (int i = 0; i < 9; i++) tx_buf[i] = 8'($urandom());
      write_txn(16'd6, 9, -1);
      tx_buf[0] = 8'h9C;
      write_txn(16'd7, 1, -1);
      read_txn(16'd6, 9, 1'b0, 1'b0);
      read_txn(16'd4, 5, 1'b0, 1'b0);
      rd_coll();

      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 4))
            0, 1: begin
               op = $urandom_range(0, 7);
               n  = $urandom_range(1, len_of(op) + 1);
               for (int i = 0; i < 16; i++) tx_buf[i] = 8'($urandom());
               coll = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
               write_txn(16'(op), n, coll);
            end
            2: begin
               op = $urandom_range(0, 7);
               read_txn(16'(op), $urandom_range(1, len_of(op) + 1), 1'b1, 1'b0);
            end
            3: begin
               op = ($urandom_range(0, 1) == 0) ? 1 : int'($urandom_range(8, 16'hFFFF));
               read_txn(16'(op), 1, 1'b0, 1'($urandom_range(0, 1)));
            end
            default: begin
               if ($urandom_range(0, 1) == 0) clear_bad();
               else rd_coll();
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
